td4_prog_loader: RTL and testbench

Writable 16×8 instruction store for the TD4 core, replacing the fixed program ROM. It sits directly upstream of the CPU: it receives program bytes over a valid/ready byte stream and holds the CPU in reset while loading. Once loaded, it serves `{op, im}` for the CPU's program counter and releases the CPU.

---
 rtl/td4_prog_loader.sv | 134 +++++++++++++
 tb/tb_td4_prog_loader.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/td4_prog_loader.sv
// td4_prog_loader: writable 16x8 TD4 program store. It is filled over a valid/ready byte stream
// and holds the CPU in reset while loading. Define TD4_LOAD_CHECKSUM_EN to require a trailing checksum byte.
module td4_prog_loader #(
  parameter int WORDS = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ld_start,
  input  logic       ld_valid,
  input  logic [7:0] ld_data,
  output logic       ld_ready,
  input  logic [3:0] pc,
  output logic [3:0] op,
  output logic [3:0] im,
  output logic       cpu_rst,
  output logic       done,
  output logic       err
);
  localparam logic [3:0] LAST_ADDR = 4'(WORDS - 1);

`ifdef TD4_LOAD_CHECKSUM_EN
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CHECK, S_RELEASE, S_RUN} state_t;
  localparam state_t S_AFTER_LOAD = S_CHECK;
`else
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RELEASE, S_RUN} state_t;
  localparam state_t S_AFTER_LOAD = S_RELEASE;
`endif

  state_t     r_state;
  state_t     w_state_next;
  logic [7:0] r_mem [16];
  logic [3:0] r_wa;
  logic       w_start;
  logic       w_write;

`ifdef TD4_LOAD_CHECKSUM_EN
  logic [7:0] r_sum;
  logic       r_err;
  logic [7:0] w_sum_final;
  logic       w_ck_bad;

  assign w_sum_final = r_sum + ld_data;
`endif

  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    w_write      = 1'b0;
    ld_ready     = 1'b0;
    cpu_rst      = 1'b1;
    done         = 1'b0;
`ifdef TD4_LOAD_CHECKSUM_EN
    w_ck_bad     = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (ld_start) begin
          w_start      = 1'b1;
          w_state_next = S_LOAD;
        end
      end
      S_LOAD: begin
        ld_ready = 1'b1;
        if (ld_valid) begin
          w_write = 1'b1;
          if (r_wa == LAST_ADDR) w_state_next = S_AFTER_LOAD;
        end
      end
`ifdef TD4_LOAD_CHECKSUM_EN
      S_CHECK: begin
        ld_ready = 1'b1;
        if (ld_valid) begin
          if (w_sum_final == 8'h00) begin
            w_state_next = S_RELEASE;
          end else begin
            w_ck_bad     = 1'b1;
            w_state_next = S_IDLE;
          end
        end
      end
`endif
      // One cycle of CPU reset after the final write, so the CPU restarts at PC 0 on the new program.
      S_RELEASE: w_state_next = S_RUN;
      S_RUN: begin
        cpu_rst = 1'b0;
        done    = 1'b1;
        if (ld_start) begin
          w_start      = 1'b1;
          w_state_next = S_LOAD;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_wa    <= 4'd0;
      for (int i = 0; i < 16; i++) r_mem[i] <= 8'h00;
    end else begin
      r_state <= w_state_next;
      if (w_start) begin
        r_wa <= 4'd0;
      end else if (w_write) begin
        r_mem[r_wa] <= ld_data;
        r_wa        <= r_wa + 4'd1;
      end
    end
  end

`ifdef TD4_LOAD_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sum <= 8'h00;
      r_err <= 1'b0;
    end else if (w_start) begin
      r_sum <= 8'h00;
      r_err <= 1'b0;
    end else begin
      if (w_write)  r_sum <= w_sum_final;
      if (w_ck_bad) r_err <= 1'b1;
    end
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

  assign op = r_mem[pc][7:4];
  assign im = r_mem[pc][3:0];

endmodule

// File: tb/tb_td4_prog_loader.sv
// Bench for td4_prog_loader: three instances (WORDS 16/4/2) checked every cycle against a session-level model,
// plus directed sequences for load timing, restart, checksum and mid-session reset.
module tb_td4_prog_loader;
  localparam int N = 3;
`ifdef TD4_LOAD_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  typedef struct {
    logic [3:0] pc;
    logic [3:0] op;
    logic [3:0] im;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0] rst, ld_start, ld_valid, ld_ready, cpu_rst, done, err;
  logic [7:0]   ld_data [N];
  logic [3:0]   pc [N];
  logic [3:0]   op [N];
  logic [3:0]   im [N];

  td4_prog_loader #(.WORDS(16)) u_w16 (
    .clk(clk), .rst(rst[0]), .ld_start(ld_start[0]), .ld_valid(ld_valid[0]), .ld_data(ld_data[0]),
    .ld_ready(ld_ready[0]), .pc(pc[0]), .op(op[0]), .im(im[0]), .cpu_rst(cpu_rst[0]), .done(done[0]), .err(err[0]));
  td4_prog_loader #(.WORDS(4)) u_w4 (
    .clk(clk), .rst(rst[1]), .ld_start(ld_start[1]), .ld_valid(ld_valid[1]), .ld_data(ld_data[1]),
    .ld_ready(ld_ready[1]), .pc(pc[1]), .op(op[1]), .im(im[1]), .cpu_rst(cpu_rst[1]), .done(done[1]), .err(err[1]));
  td4_prog_loader #(.WORDS(2)) u_w2 (
    .clk(clk), .rst(rst[2]), .ld_start(ld_start[2]), .ld_valid(ld_valid[2]), .ld_data(ld_data[2]),
    .ld_ready(ld_ready[2]), .pc(pc[2]), .op(op[2]), .im(im[2]), .cpu_rst(cpu_rst[2]), .done(done[2]), .err(err[2]));

  // Session-level model: what has been stored, how many bytes the session has taken, and whether the CPU runs.
  logic [7:0] m_mem [N][16];
  bit         m_active [N];
  bit         m_chk [N];
  bit         m_rel [N];
  bit         m_run [N];
  bit         m_err [N];
  int         m_cnt [N];
  int         m_sum [N];

  int         errors = 0;
  int         checks = 0;
  int         rdy_cnt;
  logic [7:0] lq [$];
  logic [7:0] prog [16];
  vec_t       vtab [16];

  function automatic int wds(input int k);
    return (k == 0) ? 16 : (k == 1) ? 4 : 2;
  endfunction

  task automatic model_step(input int k);
    if (rst[k]) begin
      for (int a = 0; a < 16; a++) m_mem[k][a] = 8'h00;
      m_active[k] = 0; m_chk[k] = 0; m_rel[k] = 0; m_run[k] = 0; m_err[k] = 0;
      m_cnt[k] = 0; m_sum[k] = 0;
    end else if (m_rel[k]) begin
      m_rel[k] = 0;
      m_run[k] = 1;
    end else if (m_active[k]) begin
      if (ld_valid[k]) begin
        if (m_chk[k]) begin
          m_active[k] = 0;
          m_chk[k]    = 0;
          if (((m_sum[k] + int'(ld_data[k])) % 256) == 0) m_rel[k] = 1;
          else m_err[k] = 1;
        end else begin
          m_mem[k][m_cnt[k]] = ld_data[k];
          m_sum[k] = (m_sum[k] + int'(ld_data[k])) % 256;
          m_cnt[k]++;
          if (m_cnt[k] == wds(k)) begin
            if (CK) m_chk[k] = 1;
            else begin
              m_active[k] = 0;
              m_rel[k]    = 1;
            end
          end
        end
      end
    end else if (ld_start[k]) begin
      m_active[k] = 1; m_cnt[k] = 0; m_sum[k] = 0; m_err[k] = 0; m_run[k] = 0;
    end
  endtask

  always @(posedge clk) begin
    for (int k = 0; k < N; k++) model_step(k);
  end

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_all();
    logic [7:0] e;
    for (int k = 0; k < N; k++) begin
      e = m_mem[k][pc[k]];
      chk($sformatf("ld_ready[%0d]", k), 8'(ld_ready[k]), 8'(m_active[k]));
      chk($sformatf("cpu_rst[%0d]", k), 8'(cpu_rst[k]), 8'(!m_run[k]));
      chk($sformatf("done[%0d]", k), 8'(done[k]), 8'(m_run[k]));
      chk($sformatf("err[%0d]", k), 8'(err[k]), 8'(m_err[k]));
      chk($sformatf("op[%0d] pc=%0d", k, pc[k]), 8'(op[k]), 8'(e[7:4]));
      chk($sformatf("im[%0d] pc=%0d", k, pc[k]), 8'(im[k]), 8'(e[3:0]));
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check_all();
  endtask

  // Start a session, send lq with random gaps (ld_start noise in gaps), optionally a checksum offset by ck_ofs.
  task automatic load(input int k, input int gap, input bit send_ck, input int ck_ofs);
    ld_start[k] = 1'b1;
    tick();
    ld_start[k] = 1'b0;
    rdy_cnt = 0;
    foreach (lq[i]) begin
      for (int g = 0; g < 4 && $urandom_range(99) < gap; g++) begin
        ld_valid[k] = 1'b0;
        ld_data[k]  = 8'($urandom);
        ld_start[k] = ($urandom_range(3) == 0);
        if (ld_ready[k]) rdy_cnt++;
        tick();
      end
      ld_start[k] = 1'b0;
      ld_valid[k] = 1'b1;
      ld_data[k]  = lq[i];
      if (ld_ready[k]) rdy_cnt++;
      tick();
    end
    if (send_ck) begin
      ld_valid[k] = 1'b1;
      ld_data[k]  = 8'((256 - m_sum[k] + ck_ofs) % 256);
      if (ld_ready[k]) rdy_cnt++;
      tick();
    end
    ld_valid[k] = 1'b0;
  endtask

  task automatic sweep_zero(input int k, input string nm);
    for (int a = 0; a < 16; a++) begin
      pc[k] = 4'(a);
      tick();
      chk($sformatf("%s op pc=%0d", nm, a), 8'(op[k]), 8'h00);
      chk($sformatf("%s im pc=%0d", nm, a), 8'(im[k]), 8'h00);
    end
    pc[k] = 4'd0;
  endtask

  initial begin
    prog = '{8'hB7, 8'h01, 8'hE1, 8'h01, 8'hE3, 8'hB6, 8'h01, 8'hE6,
             8'h01, 8'hE8, 8'hB0, 8'hB4, 8'h01, 8'hEA, 8'hB8, 8'hFF};
    vtab = '{'{4'd0, 4'hB, 4'h7}, '{4'd1, 4'h0, 4'h1}, '{4'd2, 4'hE, 4'h1}, '{4'd3, 4'h0, 4'h1},
             '{4'd4, 4'hE, 4'h3}, '{4'd5, 4'hB, 4'h6}, '{4'd6, 4'h0, 4'h1}, '{4'd7, 4'hE, 4'h6},
             '{4'd8, 4'h0, 4'h1}, '{4'd9, 4'hE, 4'h8}, '{4'd10, 4'hB, 4'h0}, '{4'd11, 4'hB, 4'h4},
             '{4'd12, 4'h0, 4'h1}, '{4'd13, 4'hE, 4'hA}, '{4'd14, 4'hB, 4'h8}, '{4'd15, 4'hF, 4'hF}};
    rst = '1; ld_start = '0; ld_valid = '0;
    for (int k = 0; k < N; k++) begin
      ld_data[k] = 8'h00;
      pc[k]      = 4'd0;
    end
    tick();
    tick();
    for (int k = 0; k < N; k++) begin
      chk($sformatf("reset cpu_rst[%0d]", k), 8'(cpu_rst[k]), 8'h01);
      chk($sformatf("reset ld_ready[%0d]", k), 8'(ld_ready[k]), 8'h00);
      chk($sformatf("reset done[%0d]", k), 8'(done[k]), 8'h00);
    end
    rst = '0;

    // Bytes offered while idle must never be written.
    ld_valid = '1;
    for (int k = 0; k < N; k++) ld_data[k] = 8'hFF;
    repeat (5) tick();
    ld_valid = '0;
    sweep_zero(0, "idle_valid");

    // Timer program at one byte per cycle.
    lq.delete();
    foreach (prog[i]) lq.push_back(prog[i]);
    load(0, 0, CK, 0);
    chk("timer ready_cycles", 8'(rdy_cnt), 8'(16 + int'(CK)));
    chk("timer release ld_ready", 8'(ld_ready[0]), 8'h00);
    chk("timer release cpu_rst", 8'(cpu_rst[0]), 8'h01);
    tick();
    chk("timer run cpu_rst", 8'(cpu_rst[0]), 8'h00);
    chk("timer run done", 8'(done[0]), 8'h01);
    for (int i = 0; i < 16; i++) begin
      pc[0] = vtab[i].pc;
      tick();
      chk($sformatf("timer op pc=%0d", vtab[i].pc), 8'(op[0]), 8'(vtab[i].op));
      chk($sformatf("timer im pc=%0d", vtab[i].pc), 8'(im[0]), 8'(vtab[i].im));
    end
    pc[0] = 4'd0;

    // WORDS=4 with random gaps; address 4 untouched.
    lq = '{8'hB3, 8'hB6, 8'hBC, 8'hB8};
    load(1, 40, CK, 0);
    chk("w4 release done", 8'(done[1]), 8'h00);
    tick();
    chk("w4 done", 8'(done[1]), 8'h01);
    pc[1] = 4'd4;
    tick();
    chk("w4 addr4", {op[1], im[1]}, 8'h00);
    foreach (lq[i]) begin
      pc[1] = 4'(i);
      tick();
      chk($sformatf("w4 addr%0d", i), {op[1], im[1]}, lq[i]);
    end

    // WORDS=2: good then bad checksum when enabled.
    lq = '{8'h10, 8'h20};
`ifdef TD4_LOAD_CHECKSUM_EN
    load(2, 0, 1'b1, 0);
    tick();
    chk("ck good done", 8'(done[2]), 8'h01);
    chk("ck good err", 8'(err[2]), 8'h00);
    load(2, 0, 1'b1, 1);
    chk("ck bad err", 8'(err[2]), 8'h01);
    chk("ck bad ld_ready", 8'(ld_ready[2]), 8'h00);
    repeat (3) tick();
    chk("ck bad cpu_rst", 8'(cpu_rst[2]), 8'h01);
    chk("ck bad done", 8'(done[2]), 8'h00);
`else
    load(2, 0, 1'b0, 0);
    tick();
    chk("w2 done", 8'(done[2]), 8'h01);
    chk("w2 err", 8'(err[2]), 8'h00);
`endif

    // Restart from RUN, reload with zeros (the start pulse inside load is ignored in LOAD).
    ld_start[0] = 1'b1;
    tick();
    ld_start[0] = 1'b0;
    chk("restart done", 8'(done[0]), 8'h00);
    chk("restart cpu_rst", 8'(cpu_rst[0]), 8'h01);
    lq.delete();
    repeat (16) lq.push_back(8'h00);
    load(0, 20, CK, 0);
    tick();
    sweep_zero(0, "zero_reload");

    // Reset after 7 of 16 bytes, then a fresh session starting at address 0.
    lq.delete();
    for (int i = 0; i < 7; i++) lq.push_back(prog[i]);
    load(0, 0, 1'b0, 0);
    rst[0] = 1'b1;
    tick();
    rst[0] = 1'b0;
    chk("midrst ld_ready", 8'(ld_ready[0]), 8'h00);
    chk("midrst cpu_rst", 8'(cpu_rst[0]), 8'h01);
    chk("midrst done", 8'(done[0]), 8'h00);
    sweep_zero(0, "midrst");
    lq = '{8'h5A};
    load(0, 0, 1'b0, 0);
    chk("fresh addr0", {op[0], im[0]}, 8'h5A);
    lq.delete();
    repeat (15) lq.push_back(8'($urandom));
    load(0, 30, CK, 0);
    tick();
    chk("fresh done", 8'(done[0]), 8'h01);

    // Random traffic on all instances.
    for (int c = 0; c < 800; c++) begin
      for (int k = 0; k < N; k++) begin
        rst[k]      = ($urandom_range(149) == 0);
        ld_start[k] = ($urandom_range(11) == 0);
        ld_valid[k] = ($urandom_range(1) == 0);
        ld_data[k]  = 8'($urandom);
        pc[k]       = 4'($urandom);
      end
      tick();
    end
    rst = '0; ld_start = '0; ld_valid = '0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
